// File: rtl/axis_if.sv
// AXI-Stream link carrying received I2C frames (valid/ready/data only).
interface axis_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_i2c_rx.sv
// I2C slave receiver: oversamples scl/sda, ACKs an address byte matching
// OWN_ADDR plus one data byte, and hands {data, addr/RW} to a 1-entry
// AXI-Stream output buffer.
//
//   state       | meaning
//   ------------+-----------------------------------------------------
//   S_IDLE      | bus free, waiting for START
//   S_ADDR      | shifting in the address/RW byte
//   S_ACK_A     | driving the address ACK slot
//   S_DATA      | shifting in the data byte
//   S_ACK_D     | data ACK slot (ACK only if the buffer was empty)
//   S_WAIT_STOP | frame done, waiting for STOP or repeated START
//   S_IGNORE    | address mismatch, follow the bus until STOP/START
module axis_i2c_rx #(
    parameter int                        I2C_ADDR_WIDTH  = 7,
    parameter int                        I2C_DATA_WIDTH  = 8,
    parameter int                        AXIS_DATA_WIDTH = I2C_DATA_WIDTH * 2,
    parameter logic [I2C_ADDR_WIDTH-1:0] OWN_ADDR        = 7'h2A,
    parameter bit                        LSB_FIRST       = 1'b1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   scl,
    input  logic   sda,
    output logic   sda_oe,
    axis_if.master m_axis,
    output logic   overflow,
    output logic   frame_err
);

    localparam int             CNT_W = $clog2(I2C_DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(I2C_DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ACK_A, S_DATA, S_ACK_D, S_WAIT_STOP, S_IGNORE
    } state_t;

    state_t                      state, state_n;
    logic [2:0]                  scl_sr, sda_sr;
    logic [CNT_W-1:0]            bit_cnt, cnt_n;
    logic                        byte_full, full_n;
    logic [I2C_DATA_WIDTH-1:0]   shreg, shreg_n;
    logic [I2C_DATA_WIDTH-1:0]   addr_byte, addr_n;
    logic                        oe_n, ovf_n, ferr_n, load;
    logic                        tvalid_r;
    logic [AXIS_DATA_WIDTH-1:0]  tdata_r;

    // [1] is the synchronised sample, [2] its one-cycle history
    logic scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c;
    logic [CNT_W-1:0] bit_idx;

    assign scl_s    = scl_sr[1];
    assign sda_s    = sda_sr[1];
    assign scl_rise = scl_s & ~scl_sr[2];
    assign scl_fall = ~scl_s & scl_sr[2];
    assign start_c  = scl_s & sda_sr[2] & ~sda_s;
    assign stop_c   = scl_s & ~sda_sr[2] & sda_s;
    assign bit_idx  = LSB_FIRST ? bit_cnt : LAST - bit_cnt;

    assign m_axis.tvalid = tvalid_r;
    assign m_axis.tdata  = tdata_r;

    // Synchronise the bus pins and keep one history sample for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sr <= 3'b111;
            sda_sr <= 3'b111;
        end else begin
            scl_sr <= {scl_sr[1:0], scl};
            sda_sr <= {sda_sr[1:0], sda};
        end
    end

    // FSM state and receive datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            byte_full <= 1'b0;
            shreg     <= '0;
            addr_byte <= '0;
            sda_oe    <= 1'b0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= cnt_n;
            byte_full <= full_n;
            shreg     <= shreg_n;
            addr_byte <= addr_n;
            sda_oe    <= oe_n;
            overflow  <= ovf_n;
            frame_err <= ferr_n;
        end
    end

    // Next-state logic; bus START/STOP overrides everything else
    always_comb begin
        state_n = state;
        cnt_n   = bit_cnt;
        full_n  = byte_full;
        shreg_n = shreg;
        addr_n  = addr_byte;
        oe_n    = sda_oe;
        ovf_n   = 1'b0;
        ferr_n  = 1'b0;
        load    = 1'b0;

        if (start_c || stop_c) begin
            if (((state == S_ADDR || state == S_DATA) && bit_cnt != '0) ||
                state == S_ACK_A)
                ferr_n = 1'b1;
            oe_n    = 1'b0;
            cnt_n   = '0;
            full_n  = 1'b0;
            state_n = start_c ? S_ADDR : S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_WAIT_STOP, S_IGNORE: begin
                    oe_n = 1'b0;
                end
                S_ADDR, S_DATA: begin
                    if (scl_rise && !byte_full) begin
                        shreg_n[bit_idx] = sda_s;
                        cnt_n = bit_cnt + 1'b1;
                        if (bit_cnt == LAST)
                            full_n = 1'b1;
                    end else if (scl_fall && byte_full) begin
                        full_n = 1'b0;
                        if (state == S_ADDR) begin
                            addr_n = shreg;
                            if (shreg[I2C_ADDR_WIDTH-1:0] == OWN_ADDR) begin
                                oe_n    = 1'b1;
                                state_n = S_ACK_A;
                            end else begin
                                state_n = S_IGNORE;
                            end
                        end else begin
                            state_n = S_ACK_D;
                            if (!tvalid_r)
                                oe_n = 1'b1;
                            else
                                ovf_n = 1'b1;
                        end
                    end
                end
                S_ACK_A: begin
                    if (scl_fall) begin
                        oe_n    = 1'b0;
                        state_n = S_DATA;
                    end
                end
                S_ACK_D: begin
                    if (scl_fall) begin
                        load    = sda_oe;
                        oe_n    = 1'b0;
                        state_n = S_WAIT_STOP;
                    end
                end
                default: begin
                    oe_n    = 1'b0;
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    // One-entry output buffer; a load wins over a same-cycle handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            tvalid_r <= 1'b0;
            tdata_r  <= '0;
        end else if (load) begin
            tvalid_r <= 1'b1;
            tdata_r  <= {shreg, addr_byte};
        end else if (tvalid_r && m_axis.tready) begin
            tvalid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_i2c_rx.sv
// Bench for axis_i2c_rx: an I2C master model drives frames, a scoreboard
// queue holds expected output words, a monitor pops and compares beats.
module tb_axis_i2c_rx;

    localparam logic [6:0] OWN = 7'h2A;

    logic clk = 1'b0;
    logic rst, scl, sda_m, sda_oe, overflow, frame_err, sda_line;
    assign sda_line = sda_m & ~sda_oe;

    axis_if #(.DATA_WIDTH(16)) axis ();

    axis_i2c_rx #(
        .I2C_ADDR_WIDTH(7), .I2C_DATA_WIDTH(8), .AXIS_DATA_WIDTH(16),
        .OWN_ADDR(OWN), .LSB_FIRST(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda_line), .sda_oe(sda_oe),
        .m_axis(axis), .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [15:0] exp_q[$];
    int exp_ovf = 0, exp_ferr = 0, exp_acks = 0;
    int ovf_cnt = 0, ferr_cnt = 0, oe_rises = 0;
    bit bus_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops, hold-while-stalled checks, pulse counting
    logic        prev_v = 1'b0, prev_r = 1'b0, prev_rst = 1'b1, prev_oe = 1'b0;
    logic [15:0] prev_d = '0;
    always @(negedge clk) begin
        logic [15:0] w;
        if (!rst && !prev_rst) begin
            if (axis.tvalid && axis.tready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat actual=%h expected=none", axis.tdata);
                end else begin
                    w = exp_q.pop_front();
                    check("beat_tdata", axis.tdata, w);
                end
            end
            if (prev_v && !prev_r) begin
                check("hold_tvalid", axis.tvalid, 1);
                check("hold_tdata", axis.tdata, prev_d);
            end
            if (overflow)  ovf_cnt++;
            if (frame_err) ferr_cnt++;
            if (sda_oe && !prev_oe) oe_rises++;
        end
        prev_v = axis.tvalid; prev_r = axis.tready; prev_d = axis.tdata;
        prev_rst = rst; prev_oe = sda_oe;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_out(input bit b);
        tick(4); sda_m = b; tick(4); scl = 1'b1; tick(8); scl = 1'b0;
    endtask

    task automatic ack_slot(output bit acked);
        tick(4); sda_m = 1'b1; tick(4); scl = 1'b1;
        tick(4); acked = (sda_line == 1'b0);
        tick(4); scl = 1'b0;
    endtask

    task automatic send_start;
        if (bus_busy) begin
            tick(4); sda_m = 1'b1; tick(4); scl = 1'b1; tick(8);
        end else begin
            sda_m = 1'b1; scl = 1'b1; tick(8);
        end
        sda_m = 1'b0; tick(8); scl = 1'b0; bus_busy = 1'b1;
    endtask

    task automatic send_stop;
        tick(4); sda_m = 1'b0; tick(4); scl = 1'b1; tick(8); sda_m = 1'b1; tick(8);
        bus_busy = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output bit acked);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        ack_slot(acked);
    endtask

    // Reference: ACK address iff it matches; ACK data iff no word is pending
    task automatic frame(input logic [6:0] a, input bit rw, input logic [7:0] d, input bit do_stop);
        bit aa, da, ea, ed;
        ea = (a == OWN);
        send_start;
        send_byte({rw, a}, aa);
        check("addr_ack", aa, ea);
        if (ea) begin
            exp_acks++;
            ed = (exp_q.size() == 0);
            send_byte(d, da);
            check("data_ack", da, ed);
            if (ed) begin
                exp_acks++;
                exp_q.push_back({d, rw, a});
            end else begin
                exp_ovf++;
            end
        end
        if (do_stop || !ea) send_stop;
    endtask

    initial begin
        bit aa;
        int base_oe, base_ovf, base_ferr;
        rst = 1'b1; scl = 1'b1; sda_m = 1'b1; axis.tready = 1'b1;
        tick(4);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_tvalid", axis.tvalid, 0);
        check("rst_tdata", axis.tdata, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_err", frame_err, 0);
        rst = 1'b0;
        tick(4);

        // basic frame
        base_oe = oe_rises; base_ovf = ovf_cnt; base_ferr = ferr_cnt;
        frame(OWN, 1'b0, 8'hA5, 1'b1);
        tick(4);
        check("basic_oe_slots", oe_rises - base_oe, 2);
        check("basic_no_ovf", ovf_cnt - base_ovf, 0);
        check("basic_no_ferr", ferr_cnt - base_ferr, 0);
        check("basic_drained", exp_q.size(), 0);

        // address mismatch, then a normal frame
        base_oe = oe_rises;
        frame(7'h11, 1'b0, 8'h00, 1'b1);
        check("mismatch_no_oe", oe_rises - base_oe, 0);
        frame(OWN, 1'b0, 8'h5A, 1'b1);

        // backpressure
        tick(4);
        axis.tready = 1'b0;
        frame(OWN, 1'b0, 8'h11, 1'b1);
        frame(OWN, 1'b0, 8'h22, 1'b1);
        check("bp_tvalid", axis.tvalid, 1);
        check("bp_tdata", axis.tdata, 16'h112A);
        axis.tready = 1'b1;
        tick(4);
        check("bp_drained", exp_q.size(), 0);
        check("bp_tvalid_low", axis.tvalid, 0);

        // repeated START
        frame(OWN, 1'b0, 8'h3C, 1'b0);
        frame(OWN, 1'b1, 8'h7E, 1'b1);

        // truncated data byte
        send_start;
        send_byte({1'b0, OWN}, aa);
        check("trunc_addr_ack", aa, 1);
        exp_acks++;
        for (int i = 0; i < 4; i++) bit_out(1'b1);
        send_stop;
        exp_ferr++;
        tick(2);
        check("trunc_oe", sda_oe, 0);
        check("trunc_tvalid", axis.tvalid, 0);

        // reset during the data ACK slot
        send_start;
        send_byte({1'b0, OWN}, aa);
        check("rst_addr_ack", aa, 1);
        exp_acks++;
        for (int i = 0; i < 8; i++) bit_out(1'($urandom));
        sda_m = 1'b1;
        tick(6);
        check("oe_before_rst", sda_oe, 1);
        exp_acks++;
        rst = 1'b1; tick(1);
        check("oe_after_rst", sda_oe, 0);
        check("tvalid_after_rst", axis.tvalid, 0);
        rst = 1'b0;
        tick(1); scl = 1'b1; tick(8); scl = 1'b0;
        base_oe = oe_rises;
        for (int i = 0; i < 6; i++) bit_out(1'($urandom));
        check("post_rst_no_oe", oe_rises - base_oe, 0);
        send_stop;
        frame(OWN, 1'b0, 8'hC3, 1'b1);

        // reset empties a held buffer
        axis.tready = 1'b0;
        frame(OWN, 1'b1, 8'h99, 1'b1);
        check("held_tvalid", axis.tvalid, 1);
        rst = 1'b1; tick(1);
        check("rst_empties_buf", axis.tvalid, 0);
        rst = 1'b0;
        exp_q.delete();
        axis.tready = 1'b1;
        tick(4);

        // randomized frames, tready fixed per frame
        for (int n = 0; n < 30; n++) begin
            logic [6:0] a;
            a = ($urandom_range(0, 2) != 0) ? OWN : 7'($urandom);
            axis.tready = ($urandom_range(0, 2) != 0);
            frame(a, 1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
        end
        if (bus_busy) send_stop;

        axis.tready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(1);
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d expected=0 words pending", exp_q.size());
        end
        tick(4);
        check("total_overflow", ovf_cnt, exp_ovf);
        check("total_frame_err", ferr_cnt, exp_ferr);
        check("total_ack_slots", oe_rises, exp_acks);
        check("final_oe", sda_oe, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_i2c_rx.md
# axis_i2c_rx

I2C-bus receiver: the far-end counterpart of our AXI-Stream-fed I2C transmitter. It oversamples the `scl`/`sda` lines in the system clock domain and detects START and STOP conditions. It deserialises one address/RW byte plus one data byte and presents each complete, address-matched frame as a single 16-bit word on an AXI-Stream master port. It acknowledges by pulling `sda` low through an open-drain enable. It sits at the board-facing edge of a peripheral or loopback test harness.

## Interface
- `I2C_ADDR_WIDTH`, 7: address field width.
- `I2C_DATA_WIDTH`, 8: data field width.
- `AXIS_DATA_WIDTH`, `I2C_DATA_WIDTH*2`: output word width.
- `OWN_ADDR`, 7'h2A: address this block answers to.
- `LSB_FIRST`, 1: bit order on the wire; 1 = bit 0 first, matching our transmitter.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous and active-high.
- `scl`  in  1  bus clock, asynchronous to `clk`.
- `sda`  in  1  bus data, asynchronous to `clk`.
- `sda_oe`  out  1  1 = pull `sda` low (ACK); 0 = release.
- `m_axis`  axis_if.master  `AXIS_DATA_WIDTH`  received frame; uses `tvalid`, `tready`, `tdata`.
- `overflow`  out  1  one-cycle pulse: frame dropped because the output buffer was full.
- `frame_err`  out  1  one-cycle pulse: STOP or repeated START inside a byte.

## Operation
- Input conditioning:
  - `scl` and `sda` each pass through a 2-flop synchroniser, then a third history flop.
  - Edges are detected on synchronised samples only.
  - `scl_rise` / `scl_fall` are defined from the synchronised `scl`.
- Bus conditions:
  - START = synchronised `sda` falls while synchronised `scl` is 1.
  - STOP = synchronised `sda` rises while synchronised `scl` is 1.
  - Both are evaluated every cycle, in every state.
- Bit sampling:
  - Data bits are sampled on `scl_rise`.
  - `sda_oe` changes only on `scl_fall`.
- Shift register: 8 bits per byte, with a 3-bit counter that wraps 7→0 at the byte end.
  - `LSB_FIRST`=1: the first bit lands at bit 0.
  - `LSB_FIRST`=0: the first bit lands at bit 7.
- Address byte layout: bits [6:0] = address, bit 7 = RW (transmitter ordering).
- FSM states:
  - **IDLE**: START → ADDR, counter cleared.
  - **ADDR**: 8 bits sampled, then go to ACK_A on the `scl_fall` after the 8th bit. `sda_oe` is set on that same edge if address == `OWN_ADDR`; on mismatch go to IGNORE instead.
  - **ACK_A**: on the next `scl_fall`, `sda_oe`←0 → DATA.
  - **DATA**: 8 bits, then go to ACK_D on the `scl_fall` after the 8th bit.
    - `sda_oe`←1 if the output buffer is empty.
    - Otherwise `sda_oe` stays 0 and `overflow` pulses once.
  - **ACK_D**: on the next `scl_fall`, `sda_oe`←0 → WAIT_STOP. If ACKed, load the buffer with `tdata` = {data byte, address byte} and set `tvalid`.
  - **WAIT_STOP**: STOP → IDLE; START → ADDR (repeated START).
  - **IGNORE**: `sda_oe` held 0; STOP → IDLE; START → ADDR.
- Precedence and errors:
  - START or STOP beats bit sampling in the same cycle.
  - If START or STOP is detected in ADDR or DATA with the counter ≠ 0, or in ACK_A, pulse `frame_err`, drop the partial byte and clear `sda_oe`. Then STOP → IDLE, START → ADDR.
- Output buffer (1 entry):
  - `tvalid` stays high until `tvalid && tready`.
  - `tdata` is stable while `tvalid` is high.
  - `tvalid` clears on the handshake cycle.
  - A load and a handshake in the same cycle leaves `tvalid` high with the new data.

## Timing
- Reset values: state IDLE, `sda_oe`=0, `m_axis.tvalid`=0, `m_axis.tdata`=0, `overflow`=0, `frame_err`=0, synchroniser flops = 1.
- `rst` asserted mid-frame:
  - next cycle: IDLE, `sda_oe` released, buffer emptied;
  - the bus is then ignored until a fresh START.
- Detection latency: 3 `clk` cycles from a pin edge to the internal event.
- Output latency: `tvalid` rises 1 cycle after the internal `scl_fall` that ends ACK_D.
- Clock requirement: `scl` high and low phases ≥ 4 `clk` cycles each. `sda` must be stable ≥ 2 `clk` cycles around each `scl` edge.
- Tie-breaks: `m_axis.tready` has no combinational path to any output; `tready` is ignored when `tvalid`=0.

## Test plan
- **Basic frame:** START, address 0x2A, RW=0, data 0xA5 (LSB first), STOP, `tready`=1 → `sda_oe`=1 for exactly both ACK slots, one beat `tdata`=16'hA52A, no error pulses.
- **Address mismatch:** START, address 0x11 → `sda_oe` never asserted, no `tvalid`; the bus is followed to STOP; the next frame to 0x2A is accepted normally.
- **Backpressure:** `tready`=0 while two frames are sent → first frame held with `tdata` stable, second data byte NACKed, `overflow` pulses once; `tready`=1 → only the first word is delivered.
- **Repeated START:** START, 0x2A, 0x3C, repeated START, 0x2A|RW, 0x7E, STOP → two beats, 16'h3C2A then 16'h7EAA.
- **Truncated byte:** STOP after 4 data bits → `frame_err` pulse, no `tvalid`, state IDLE, `sda_oe`=0.
- **Reset during DATA with `sda_oe`=1:** `rst` for 1 cycle → `sda_oe`=0 next cycle, no `tvalid`; remaining bits are ignored until a new START.
